// File: rtl/uart_pkg.sv
// Shared UART constants: character width, ASCII control codes, default FIFO depth.
// Also holds the feed-state type used when CR/LF expansion is enabled.
package uart_pkg;
    localparam int CHAR_W  = 7;
    localparam int FIFO_AW = 4;

    localparam logic [CHAR_W-1:0] ASCII_LF = 7'h0A;
    localparam logic [CHAR_W-1:0] ASCII_CR = 7'h0D;

    typedef enum logic {
        SEND_CHAR = 1'b0,
        SEND_LF   = 1'b1
    } feed_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port, status flags and transmitter load/ready handshake.
// master = producer/transmitter side (testbench or SoC glue), slave = the FIFO.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int CW = CHAR_W
);
    logic          wr;
    logic [CW-1:0] din;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          idle;
    logic          tx_load;
    logic [CW-1:0] tx_data;
    logic          tx_ready;

    modport master (
        output wr, din, tx_ready,
        input  full, empty, level, overflow, idle, tx_load, tx_data
    );

    modport slave (
        input  wr, din, tx_ready,
        output full, empty, level, overflow, idle, tx_load, tx_data
    );
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x CW register array, one synchronous write port, one asynchronous read port.
// Array is not reset; validity is tracked entirely by the pointers in the parent.
module uart_fifo_ram #(
    parameter int AW = 4,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);
    logic [CW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Character FIFO feeding the UART transmitter; UART_TX_CRLF_EN expands LF into CR,LF.
// Latency: a write at edge N is offered on tx_load in the cycle after N (no bypass).
// Backpressure: full rejects writes (sticky overflow); tx_load only while tx_ready.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int CW = CHAR_W
) (
    input  logic clk,
    input  logic rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fill;
    logic          push;
    logic          pop;
    logic [CW-1:0] head;

    // Extra wrap bit lets the plain difference distinguish full from empty.
    assign fill      = wr_ptr - rd_ptr;
    assign bus.level = fill;
    assign bus.full  = (fill == DEPTH);
    assign bus.empty = (wr_ptr == rd_ptr);

    assign push        = bus.wr & ~bus.full;
    assign bus.tx_load = bus.tx_ready & ~bus.empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.wr & bus.full) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    uart_fifo_ram #(
        .AW (AW),
        .CW (CW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.din),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

`ifdef UART_TX_CRLF_EN
    feed_state_e   state;
    feed_state_e   state_nxt;
    logic [CW-1:0] feed_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEND_CHAR;
        end else begin
            state <= state_nxt;
        end
    end

    // An LF at the head is sent twice: first as CR without popping, then as itself.
    always_comb begin
        state_nxt = state;
        feed_dat  = head;
        pop       = bus.tx_load;
        case (state)
            SEND_CHAR: begin
                if (head == CW'(ASCII_LF)) begin
                    feed_dat = CW'(ASCII_CR);
                    pop      = 1'b0;
                    if (bus.tx_load) begin
                        state_nxt = SEND_LF;
                    end
                end
            end
            SEND_LF: begin
                if (bus.tx_load) begin
                    state_nxt = SEND_CHAR;
                end
            end
            default: state_nxt = SEND_CHAR;
        endcase
    end

    assign bus.tx_data = feed_dat;
    assign bus.idle    = bus.empty & bus.tx_ready & (state == SEND_CHAR);
`else
    assign pop         = bus.tx_load;
    assign bus.tx_data = head;
    assign bus.idle    = bus.empty & bus.tx_ready;
`endif
endmodule
